// File: rtl/acc_apb_pkg.sv
// Shared constants and types for the accelerator APB initiator.
package acc_apb_pkg;

    // Accelerator register map
    localparam logic [11:0] ACC_CTRL_ADDR   = 12'hFF0;
    localparam logic [11:0] ACC_FILTER_ADDR = 12'hFF4;
    localparam logic [11:0] ACC_MATRIX_ADDR = 12'hFF8;
    localparam logic [31:0] ACC_START_VAL   = 32'd1;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // Response status codes
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/acc_cmd_fifo.sv
// Small synchronous command FIFO with registered occupancy count.
module acc_cmd_fifo
    import acc_apb_pkg::*;
#(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push while full is refused even if a pop happens in the same cycle
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/acc_apb_master.sv
// APB initiator: turns a valid/ready command stream into APB transfers,
// one response per command, with a PREADY timeout for forward progress.
module acc_apb_master
    import acc_apb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int ENT_W  = 1 + ADDR_W + DATA_W;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    // Keep at least one bit so TIMEOUT=0 still elaborates
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_t        r_state;
    logic [CNT_W-1:0]  r_wait;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FCNT_W-1:0] w_count;
    logic [ENT_W-1:0]  w_head;
    logic              w_head_write;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    // Pop when idle, or straight out of RESP on a handshake to skip IDLE
    assign w_pop     = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
    assign busy      = (w_count != '0) || (r_state != ST_IDLE);

    assign {w_head_write, w_head_addr, w_head_wdata} = w_head;

    acc_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({cmd_write, cmd_addr, cmd_wdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= RSP_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        PADDR   <= w_head_addr;
                        PWRITE  <= w_head_write;
                        PWDATA  <= w_head_write ? w_head_wdata : '0;
                        PSEL    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_wait  <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so it wins over the last timeout cycle
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR ? RSP_SLVERR : RSP_OK;
                        r_state   <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (r_wait == CNT_W'(TIMEOUT - 1))) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= RSP_TIMEOUT;
                        r_state   <= ST_RESP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_pop) begin
                            PADDR   <= w_head_addr;
                            PWRITE  <= w_head_write;
                            PWDATA  <= w_head_write ? w_head_wdata : '0;
                            PSEL    <= 1'b1;
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_apb_master.sv
// Directed bench for acc_apb_master with a scripted APB slave.
module tb_acc_apb_master;
    import acc_apb_pkg::*;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 8;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_chk  = 0;
    int n_fail = 0;

    acc_apb_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from idle and follow it to its response.
    // PREADY rises in ACCESS cycle number rdy (0 = never).
    task automatic run_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input int rdy, input logic serr, input logic [31:0] rd,
                           output int acc, output logic [31:0] rdata, output logic [1:0] err,
                           output logic psel_resp);
        bit got;
        acc = 0; got = 0; rdata = '0; err = '0; psel_resp = 1'b1;
        PSLVERR = serr; PRDATA = rd; PREADY = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (rsp_valid) begin
                got = 1; rdata = rsp_rdata; err = rsp_err; psel_resp = PSEL | PENABLE;
            end else begin
                if (PSEL && PENABLE) begin
                    acc++;
                    PREADY = (rdy != 0) && (acc >= rdy);
                end
                @(negedge clk);
            end
        end
        PREADY = 1'b0;
        if (!got) chk("rsp_arrived", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int          acc;
        logic [31:0] rdata;
        logic [1:0]  err;
        logic        pr;
        int          idx;
        int          nrsp;
        int          last_c;
        int          seen;
        bit          hit;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write to filter register, PREADY tied high: phase timing
        PREADY = 1'b1; PSLVERR = 1'b0; rsp_ready = 1'b1; PRDATA = 32'h55AA55AA;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ACC_FILTER_ADDR; cmd_wdata = 32'h00010203;
        chk("t1_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_psel_n1", PSEL, 0);
        chk("t1_busy_n1", busy, 1);
        @(negedge clk);
        chk("t1_psel_setup", PSEL, 1);
        chk("t1_penable_setup", PENABLE, 0);
        chk("t1_paddr_setup", PADDR, 12'hFF4);
        chk("t1_pwrite_setup", PWRITE, 1);
        chk("t1_pwdata_setup", PWDATA, 32'h00010203);
        @(negedge clk);
        chk("t1_psel_access", PSEL, 1);
        chk("t1_penable_access", PENABLE, 1);
        chk("t1_paddr_access", PADDR, 12'hFF4);
        chk("t1_pwdata_access", PWDATA, 32'h00010203);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 2'b00);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_psel_resp", PSEL, 0);
        @(negedge clk);
        chk("t1_rsp_done", rsp_valid, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_paddr_hold", PADDR, 12'hFF4);
        PREADY = 1'b0;

        // Read matrix register with 3 wait states
        run_cmd(1'b0, ACC_MATRIX_ADDR, 32'hFFFFFFFF, 4, 1'b0, 32'hDEADBEEF, acc, rdata, err, pr);
        chk("t2_access_cycles", acc, 4);
        chk("t2_rdata", rdata, 32'hDEADBEEF);
        chk("t2_err", err, 2'b00);
        chk("t2_pwdata_read", PWDATA, 0);
        chk("t2_pwrite_read", PWRITE, 0);

        // Slave never ready: timeout after exactly TIMEOUT ACCESS cycles
        run_cmd(1'b0, ACC_CTRL_ADDR, 32'h0, 0, 1'b0, 32'hCAFEF00D, acc, rdata, err, pr);
        chk("t3_access_cycles", acc, TIMEOUT);
        chk("t3_err", err, 2'b10);
        chk("t3_rdata", rdata, 0);
        chk("t3_psel_resp", pr, 0);

        // Slave error on a write, then on a read (read data still returned)
        run_cmd(1'b1, ACC_CTRL_ADDR, ACC_START_VAL, 1, 1'b1, 32'h77777777, acc, rdata, err, pr);
        chk("t5_wr_err", err, 2'b01);
        chk("t5_wr_rdata", rdata, 0);
        run_cmd(1'b0, ACC_FILTER_ADDR, 32'h0, 2, 1'b1, 32'h12345678, acc, rdata, err, pr);
        chk("t5_rd_err", err, 2'b01);
        chk("t5_rd_rdata", rdata, 32'h12345678);
        PSLVERR = 1'b0;

        // Backpressure: 7 reads offered with the response path stalled
        rsp_ready = 1'b0; PREADY = 1'b1; idx = 0;
        for (int c = 0; c < 12; c++) begin
            PRDATA    = {20'hC0DE0, PADDR};
            cmd_valid = (idx < 7);
            cmd_write = 1'b0;
            cmd_addr  = 12'(12'h100 + idx);
            if (cmd_valid && cmd_ready) idx++;
            @(negedge clk);
        end
        chk("t4_accepted", idx, 5);
        chk("t4_cmd_ready_full", cmd_ready, 0);
        chk("t4_rsp_held", rsp_valid, 1);
        chk("t4_rsp_held_data", rsp_rdata, {20'hC0DE0, 12'h100});
        rsp_ready = 1'b1; nrsp = 0; last_c = 0;
        for (int c = 0; c < 80 && nrsp < 7; c++) begin
            PRDATA = {20'hC0DE0, PADDR};
            if (rsp_valid) begin
                chk($sformatf("t4_rsp%0d", nrsp), rsp_rdata, {20'hC0DE0, 12'(12'h100 + nrsp)});
                if (nrsp >= 1 && nrsp <= 4) chk($sformatf("t4_gap%0d", nrsp), c - last_c, 3);
                last_c = c;
                nrsp++;
            end
            cmd_valid = (idx < 7);
            cmd_addr  = 12'(12'h100 + idx);
            if (cmd_valid && cmd_ready) idx++;
            @(negedge clk);
        end
        cmd_valid = 1'b0; PREADY = 1'b0;
        chk("t4_rsp_count", nrsp, 7);
        chk("t4_all_accepted", idx, 7);
        @(negedge clk);

        // Reset pulsed mid-ACCESS drops the command
        rsp_ready = 1'b1; PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ACC_MATRIX_ADDR;
        @(negedge clk);
        cmd_valid = 1'b0; hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (PSEL && PENABLE) hit = 1;
            else @(negedge clk);
        end
        chk("t6_reached_access", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_psel", PSEL, 0);
        chk("t6_penable", PENABLE, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        PREADY = 1'b1; seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("t6_no_rsp", seen, 0);
        PREADY = 1'b0;

        // Recovery after reset
        run_cmd(1'b0, ACC_CTRL_ADDR, 32'h0, 2, 1'b0, 32'h0BADF00D, acc, rdata, err, pr);
        chk("t7_rdata", rdata, 32'h0BADF00D);
        chk("t7_err", err, 2'b00);
        chk("t7_access_cycles", acc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_apb_master.md
# acc_apb_master

APB initiator that drives the convolution accelerator's APB slave port from a simple valid/ready command stream, e.g. a test sequencer or a small CPU-side bridge. It buffers commands in a small FIFO and runs each one as a standard two-phase APB transfer (SETUP, ACCESS). It returns one response per command with read data and error status. A PREADY timeout guarantees forward progress even if the slave never asserts PREADY.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max ACCESS cycles before abort; 0 = no timeout
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read data (0 for writes and on timeout)
- rsp_err  out  2  00 ok, 01 PSLVERR, 10 timeout
- busy  out  1  FIFO non-empty or state ≠ IDLE
- PADDR  out  ADDR_W
- PWDATA  out  DATA_W
- PWRITE  out  1
- PSEL  out  1
- PENABLE  out  1
- PRDATA  in  DATA_W
- PREADY  in  1
- PSLVERR  in  1

## Operation
- Command accepted on cmd_valid && cmd_ready; it is pushed into the FIFO. cmd_ready = !full, using registered occupancy. A push while full is never accepted, even if a pop occurs in the same cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if FIFO non-empty, pop the head into holding registers and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. PADDR and PWRITE come from the holding registers. PWDATA = wdata for writes, 0 for reads. Lasts exactly 1 cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with PADDR, PWRITE and PWDATA unchanged from SETUP.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR, then go to RESP.
  - Wait counter reaches TIMEOUT with PREADY still 0: go to RESP with err=10 and rdata=0.
  - PREADY and the final timeout cycle coincide: PREADY wins.
- RESP: PSEL=0 and rsp_valid=1; rsp_* held stable until rsp_ready.
  - On handshake with FIFO non-empty: pop the next command and go directly to SETUP.
  - Otherwise: go to IDLE.
- Error priority: 10 (timeout) is exclusive. 01 when PSLVERR=1 with PREADY=1. For a read with PSLVERR, rdata still carries PRDATA.
- Outside transfers PSEL=PENABLE=0, and PADDR, PWRITE and PWDATA hold their last values.
- Responses are returned strictly in command order, one per accepted command.
- Reset (at any time, including mid-transfer): state IDLE, FIFO emptied, and every output 0 except cmd_ready, which is 1. An in-flight command is dropped and produces no response.

## Timing
- All APB and rsp outputs are driven from registers; no combinational path from PREADY to PSEL/PENABLE.
- Command accepted at edge of cycle N:
  - IDLE pops during N+1.
  - PSEL=1 in N+2 (SETUP).
  - PENABLE=1 in N+3.
- PREADY=1 in the k-th ACCESS cycle: rsp_valid=1 in the following cycle. Minimum is 3 cycles from SETUP start to rsp_valid.
- Back-to-back with rsp_ready=1: transfers every 3 cycles (SETUP, ACCESS, RESP).
- Timeout counter:
  - Resets on entering ACCESS.
  - Counts ACCESS cycles; abort after exactly TIMEOUT ACCESS cycles with PREADY=0.
  - Width is clog2(TIMEOUT+1).

## Structure
- Package acc_apb_pkg:
  - Address constants ACC_CTRL_ADDR=12'hFF0, ACC_FILTER_ADDR=12'hFF4, ACC_MATRIX_ADDR=12'hFF8.
  - ACC_START_VAL=32'd1.
  - FSM state enum.
  - rsp_err codes RSP_OK, RSP_SLVERR, RSP_TIMEOUT.
- Sub-module acc_cmd_fifo: synchronous FIFO, width 1+ADDR_W+DATA_W.
  - Ports: push/pop, full/empty, count.
  - Synchronous active-high reset.

## Test plan
- Write 0x00010203 to 0xFF4, PREADY tied 1:
  - PSEL rises 2 cycles after accept, PENABLE 1 cycle later.
  - PADDR=0xFF4, PWRITE=1, PWDATA stable across both phases.
  - rsp_valid the next cycle with err=00, rdata=0.
- Read 0xFF8, PREADY low for 3 ACCESS cycles then high with PRDATA=0xDEADBEEF: ACCESS lasts 4 cycles; rsp_rdata=0xDEADBEEF, err=00.
- PREADY tied 0, TIMEOUT=8: ACCESS lasts exactly 8 cycles; rsp err=10, rdata=0; PSEL=0 in RESP.
- rsp_ready=0, 7 commands offered back-to-back:
  - Exactly 5 accepted (1 in flight + 4 in FIFO), then cmd_ready=0.
  - Raising rsp_ready returns 5 responses in order, then accepts the rest.
- Write 1 to 0xFF0 with PREADY=1, PSLVERR=1: rsp err=01.
- rst pulsed during ACCESS:
  - Next cycle PSEL=PENABLE=0, rsp_valid=0, busy=0, cmd_ready=1.
  - No response is ever issued for the dropped command.
